rf_writeback_queue: RTL and testbench
=====================================

// Module: rf_writeback_queue
// PURPOSE
// - Write-back side of the register-file datapath: accepts ALU results plus destination register
//   (rd = Instruction[15:11]) from the compute stage and buffers them in an in-order FIFO.
// - Drains the FIFO into the register-file write port over a we/ack handshake.
// - Bypasses pending (uncommitted) values to the Rs/Rt read addresses so reads never see stale data.
// - Holds Zero/Carry of the last committed result.
// PARAMETERS
// - DEPTH   4   FIFO entries; power of two, >= 2
// - DATA_W  32  result width
// - ADDR_W  5   register address width (32 registers)
// PORTS
// - clk         in   1       clock; all state updates on rising edge
// - rst         in   1       asynchronous, active-high reset
// - wb_valid    in   1       producer has a result
// - wb_ready    out  1       queue can accept; = !full
// - wb_addr     in   ADDR_W  destination register
// - wb_data     in   DATA_W  ALU result
// - wb_zero     in   1       ALU Zero flag of this result
// - wb_carry    in   1       ALU Carry flag of this result
// - rf_we       out  1       head entry presented to RF; = !empty
// - rf_waddr    out  ADDR_W  head destination
// - rf_wdata    out  DATA_W  head data
// - rf_wack     in   1       RF took head this cycle (valid only while rf_we=1)
// - rs_addr     in   ADDR_W  bypass query A
// - rt_addr     in   ADDR_W  bypass query B
// - rs_hit      out  1       pending entry matches rs_addr
// - rs_fwd      out  DATA_W  data of youngest matching entry; 0 when no hit
// - rt_hit      out  1       same for rt_addr
// - rt_fwd      out  DATA_W  same for rt_addr
// - last_zero   out  1       Zero of most recent commit
// - last_carry  out  1       Carry of most recent commit
// - count       out  clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
// - Reset (async, any time, incl. mid-drain): pointers=0, count=0, all entries invalid.
//   Outputs: wb_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, hits=0, fwd=0, last_zero=0, last_carry=0.
//   In-flight entries are discarded, not committed.
// - Push when wb_valid & wb_ready. Entry {addr,data,zero,carry} is written at tail; tail wraps
//   modulo DEPTH.
// - wb_addr==0: handshake completes but nothing is stored. $0 is never written, never bypassed,
//   and last_* is unchanged.
// - Pop when rf_we & rf_wack. Head advances with wrap; last_zero/last_carry load the popped entry's
//   flags on the same edge.
// - Latency: a push at edge N is visible on rf_we/rf_waddr/rf_wdata after edge N
//   (registered storage, combinational head read). No same-cycle pass-through.
// - Push and pop in the same cycle: both occur and count is unchanged. This is legal only when
//   not full, because wb_ready=0 when full even if rf_wack=1 (no full-pass-through).
// - Full: wb_ready=0 and wb_valid is ignored. Empty: rf_we=0 and rf_wack is ignored.
// - rf_waddr/rf_wdata must hold stable while rf_we=1 and rf_wack=0 (RF stall).
// - Bypass: combinational over all valid entries.
//   - Hit requires addr match and addr!=0.
//   - With multiple matches, the youngest (closest to tail) wins.
//   - An entry popped this cycle still counts as a hit this cycle.
//   - Pushes this cycle are not visible until the next cycle.
// - count: 0..DEPTH. Never exceeds DEPTH and never underflows.
// TESTING
// - Reset then push (3,0x0000_00AA), rf_wack=1 -> next cycle rf_we=1, waddr=3, wdata=0xAA;
//   after ack, count=0.
// - rf_wack=0; push 4 entries -> count=4, wb_ready=0; a 5th wb_valid is dropped.
//   Raise ack -> pops come out in order with wrap.
// - Push (7,0x11), then (7,0x22), no ack; rs_addr=7 -> rs_hit=1, rs_fwd=0x22.
//   rt_addr=0 -> rt_hit=0.
// - Push to addr 0 -> wb_ready handshake completes, count stays 0, rf_we stays 0.
// - Count=2, push and ack in the same cycle -> count stays 2; last_carry takes the popped
//   entry's carry.
// - Assert rst mid-drain with count=3 -> same cycle rf_we=0, count=0, last_*=0;
//   after release, rf_we stays 0.

Source files
------------

// File: rtl/rf_writeback_queue.sv
// ============================================================================
// rf_writeback_queue : in-order write-back FIFO feeding the register-file
//                      write port, with read bypass of pending results
// Revision 1.0
// ============================================================================
`default_nettype none

module rf_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    // producer side
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wb_zero,
    input  logic                     wb_carry,
    // register-file write port
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic                     rf_wack,
    // bypass queries
    input  logic [ADDR_W-1:0]        rs_addr,
    input  logic [ADDR_W-1:0]        rt_addr,
    output logic                     rs_hit,
    output logic [DATA_W-1:0]        rs_fwd,
    output logic                     rt_hit,
    output logic [DATA_W-1:0]        rt_fwd,
    // status
    output logic                     last_zero,
    output logic                     last_carry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    // Entry storage
    logic [ADDR_W-1:0] ent_addr_q  [DEPTH];
    logic [DATA_W-1:0] ent_data_q  [DEPTH];
    logic              ent_zero_q  [DEPTH];
    logic              ent_carry_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              last_zero_q, last_zero_d;
    logic              last_carry_q, last_carry_d;

    logic              w_full;
    logic              w_nonempty;
    logic              w_push;
    logic              w_pop;

    assign w_full     = (count_q == c_FULL_CNT);
    assign w_nonempty = (count_q != '0);

    // Writes to $0 complete the handshake but are never stored.
    assign w_push = wb_valid && !w_full && (wb_addr != '0);
    assign w_pop  = w_nonempty && rf_wack;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        last_zero_d  = last_zero_q;
        last_carry_d = last_carry_q;
        count_d      = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

        if (w_pop) begin
            head_d       = head_q + 1'b1;
            last_zero_d  = ent_zero_q[head_q];
            last_carry_d = ent_carry_q[head_q];
        end
        if (w_push) begin
            tail_d = tail_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            last_zero_q  <= 1'b0;
            last_carry_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i]  <= '0;
                ent_data_q[i]  <= '0;
                ent_zero_q[i]  <= 1'b0;
                ent_carry_q[i] <= 1'b0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            last_zero_q  <= last_zero_d;
            last_carry_q <= last_carry_d;
            if (w_push) begin
                ent_addr_q[tail_q]  <= wb_addr;
                ent_data_q[tail_q]  <= wb_data;
                ent_zero_q[tail_q]  <= wb_zero;
                ent_carry_q[tail_q] <= wb_carry;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bypass: scan oldest to youngest so the youngest match overrides.
    // The entry being popped this cycle is still inside the window.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = head_q;
        rs_hit = 1'b0;
        rs_fwd = '0;
        rt_hit = 1'b0;
        rt_fwd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if ((rs_addr != '0) && (ent_addr_q[idx] == rs_addr)) begin
                    rs_hit = 1'b1;
                    rs_fwd = ent_data_q[idx];
                end
                if ((rt_addr != '0) && (ent_addr_q[idx] == rt_addr)) begin
                    rt_hit = 1'b1;
                    rt_fwd = ent_data_q[idx];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wb_ready   = !w_full;
    assign rf_we      = w_nonempty;
    assign rf_waddr   = w_nonempty ? ent_addr_q[head_q] : '0;
    assign rf_wdata   = w_nonempty ? ent_data_q[head_q] : '0;
    assign last_zero  = last_zero_q;
    assign last_carry = last_carry_q;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
// ============================================================================
// tb_rf_writeback_queue : table-driven directed vectors, reset corner case and
//                         randomized run against a queue-based reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_rf_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_zero;
    logic              wb_carry;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_wack;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_hit;
    logic [DATA_W-1:0] rs_fwd;
    logic              rt_hit;
    logic [DATA_W-1:0] rt_fwd;
    logic              last_zero;
    logic              last_carry;
    logic [2:0]        count;

    rf_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_zero(wb_zero), .wb_carry(wb_carry),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wack(rf_wack),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_hit(rs_hit), .rs_fwd(rs_fwd), .rt_hit(rt_hit), .rt_fwd(rt_fwd),
        .last_zero(last_zero), .last_carry(last_carry), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int ready, input int we, input int waddr,
                            input int wdata, input int rsh, input int rsf, input int rth,
                            input int rtf, input int cnt, input int lz, input int lc);
        chk({tag, ".wb_ready"},   32'(wb_ready),   ready);
        chk({tag, ".rf_we"},      32'(rf_we),      we);
        chk({tag, ".rf_waddr"},   32'(rf_waddr),   waddr);
        chk({tag, ".rf_wdata"},   rf_wdata,        wdata);
        chk({tag, ".rs_hit"},     32'(rs_hit),     rsh);
        chk({tag, ".rs_fwd"},     rs_fwd,          rsf);
        chk({tag, ".rt_hit"},     32'(rt_hit),     rth);
        chk({tag, ".rt_fwd"},     rt_fwd,          rtf);
        chk({tag, ".count"},      32'(count),      cnt);
        chk({tag, ".last_zero"},  32'(last_zero),  lz);
        chk({tag, ".last_carry"}, 32'(last_carry), lc);
    endtask

    // Inputs applied at the falling edge; expected outputs are those seen
    // just before the following rising edge.
    typedef struct {
        int valid, addr, data, z, c, ack, rs, rt;
        int e_ready, e_we, e_waddr, e_wdata, e_rsh, e_rsf, e_rth, e_rtf, e_cnt, e_lz, e_lc;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              z;
        logic              c;
    } ent_t;

    vec_t tbl[16];
    ent_t mq[$];
    logic mlz, mlc;

    task automatic drive(input int v, input int a, input int d, input int z, input int c,
                         input int ack, input int rs, input int rt);
        wb_valid = v[0];
        wb_addr  = a[ADDR_W-1:0];
        wb_data  = d;
        wb_zero  = z[0];
        wb_carry = c[0];
        rf_wack  = ack[0];
        rs_addr  = rs[ADDR_W-1:0];
        rt_addr  = rt[ADDR_W-1:0];
    endtask

    initial begin
        //         valid addr data  z  c ack rs rt | rdy we wa wdata rsh rsf  rth rtf  cnt lz lc
        tbl[0]  = '{1, 3, 'hAA, 0, 1, 1, 3, 0,   1, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0, 0, 0};
        tbl[1]  = '{0, 0, 'h00, 0, 0, 1, 3, 3,   1, 1, 3, 'hAA, 1, 'hAA, 1, 'hAA, 1, 0, 0};
        tbl[2]  = '{0, 0, 'h00, 0, 0, 0, 3, 0,   1, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0, 0, 1};
        tbl[3]  = '{1, 1, 'h10, 1, 0, 0, 1, 6,   1, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0, 0, 1};
        tbl[4]  = '{1, 2, 'h20, 0, 0, 0, 1, 6,   1, 1, 1, 'h10, 1, 'h10, 0, 'h00, 1, 0, 1};
        tbl[5]  = '{1, 5, 'h50, 0, 1, 0, 1, 6,   1, 1, 1, 'h10, 1, 'h10, 0, 'h00, 2, 0, 1};
        tbl[6]  = '{1, 6, 'h60, 1, 1, 0, 1, 6,   1, 1, 1, 'h10, 1, 'h10, 0, 'h00, 3, 0, 1};
        tbl[7]  = '{1, 9, 'h99, 0, 0, 0, 1, 6,   0, 1, 1, 'h10, 1, 'h10, 1, 'h60, 4, 0, 1};
        tbl[8]  = '{0, 0, 'h00, 0, 0, 1, 9, 6,   0, 1, 1, 'h10, 0, 'h00, 1, 'h60, 4, 0, 1};
        tbl[9]  = '{1, 7, 'h11, 0, 0, 1, 2, 0,   1, 1, 2, 'h20, 1, 'h20, 0, 'h00, 3, 1, 0};
        tbl[10] = '{1, 7, 'h22, 1, 0, 0, 7, 5,   1, 1, 5, 'h50, 1, 'h11, 1, 'h50, 3, 0, 0};
        tbl[11] = '{1, 0, 'h77, 0, 0, 1, 7, 0,   0, 1, 5, 'h50, 1, 'h22, 0, 'h00, 4, 0, 0};
        tbl[12] = '{1, 0, 'h77, 0, 0, 0, 0, 7,   1, 1, 6, 'h60, 0, 'h00, 1, 'h22, 3, 0, 1};
        tbl[13] = '{0, 0, 'h00, 0, 0, 1, 0, 0,   1, 1, 6, 'h60, 0, 'h00, 0, 'h00, 3, 0, 1};
        tbl[14] = '{1, 8, 'h80, 0, 0, 1, 7, 8,   1, 1, 7, 'h11, 1, 'h22, 0, 'h00, 2, 1, 1};
        tbl[15] = '{0, 0, 'h00, 0, 0, 0, 8, 7,   1, 1, 7, 'h22, 1, 'h80, 1, 'h22, 2, 0, 0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_outs("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].valid, tbl[i].addr, tbl[i].data, tbl[i].z, tbl[i].c,
                  tbl[i].ack, tbl[i].rs, tbl[i].rt);
            #1;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_we, tbl[i].e_waddr,
                     tbl[i].e_wdata, tbl[i].e_rsh, tbl[i].e_rsf, tbl[i].e_rth,
                     tbl[i].e_rtf, tbl[i].e_cnt, tbl[i].e_lz, tbl[i].e_lc);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset asserted mid-drain with three entries pending.
        drive(1, 4, 'h44, 1, 1, 0, 7, 4);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 7, 4);
        #1;
        chk("middrain.count_before", 32'(count), 3);
        #1;
        rst = 1'b1;
        #1;
        chk_outs("async_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("post_rst%0d.rf_we", i), 32'(rf_we), 0);
            chk($sformatf("post_rst%0d.count", i), 32'(count), 0);
            @(posedge clk);
            @(negedge clk);
        end

        // Push to $0 on an empty queue: accepted, nothing stored.
        drive(1, 0, 'h5, 1, 1, 0, 0, 0);
        #1;
        chk("zero_push.ready", 32'(wb_ready), 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_outs("zero_push", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized run against a queue model.
        mq.delete();
        mlz = 1'b0;
        mlc = 1'b0;
        for (int n = 0; n < 600; n++) begin
            int    e_ready, e_we, e_wa, e_wd, e_rsh, e_rsf, e_rth, e_rtf;
            logic  do_pop, do_push;
            wb_valid = ($urandom_range(0, 9) < 7);
            wb_addr  = ADDR_W'($urandom_range(0, 7));
            wb_data  = $urandom;
            wb_zero  = 1'($urandom_range(0, 1));
            wb_carry = 1'($urandom_range(0, 1));
            rf_wack  = ($urandom_range(0, 9) < 4);
            rs_addr  = ADDR_W'($urandom_range(0, 7));
            rt_addr  = ADDR_W'($urandom_range(0, 7));
            #1;
            e_ready = (mq.size() < DEPTH) ? 1 : 0;
            e_we    = (mq.size() > 0) ? 1 : 0;
            e_wa    = (e_we != 0) ? int'(mq[0].a) : 0;
            e_wd    = (e_we != 0) ? int'(mq[0].d) : 0;
            e_rsh = 0; e_rsf = 0; e_rth = 0; e_rtf = 0;
            foreach (mq[j]) begin
                if (rs_addr != 0 && mq[j].a == rs_addr) begin e_rsh = 1; e_rsf = int'(mq[j].d); end
                if (rt_addr != 0 && mq[j].a == rt_addr) begin e_rth = 1; e_rtf = int'(mq[j].d); end
            end
            chk_outs($sformatf("rnd%0d", n), e_ready, e_we, e_wa, e_wd, e_rsh, e_rsf,
                     e_rth, e_rtf, mq.size(), int'(mlz), int'(mlc));
            do_pop  = (e_we != 0) && rf_wack;
            do_push = wb_valid && (e_ready != 0) && (wb_addr != 0);
            @(posedge clk);
            if (do_pop) begin
                mlz = mq[0].z;
                mlc = mq[0].c;
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back('{wb_addr, wb_data, wb_zero, wb_carry});
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
